// File: rtl/phase_timer_if.sv
// Handshake bundle between the traffic-light controller and its phase timer.
// The controller drives start/length and reads back flicker, done, busy and
// the remaining seconds.
interface phase_timer_if;
  logic       t_start;
  logic [4:0] t_length;
  logic       t_flicker;
  logic       t_done;
  logic       t_busy;
  logic [4:0] t_remaining;

  // Controller side: issues start requests, observes timer status.
  modport master (
    output t_start,
    output t_length,
    input  t_flicker,
    input  t_done,
    input  t_busy,
    input  t_remaining
  );

  // Timer side: accepts start requests, reports status.
  modport slave (
    input  t_start,
    input  t_length,
    output t_flicker,
    output t_done,
    output t_busy,
    output t_remaining
  );
endinterface

// File: rtl/phase_timer.sv
// Phase countdown timer for the traffic-light controller.
// A prescaler divides clk into half-second ticks; a half-second counter is
// loaded with twice the requested duration and counts down to zero. The last
// FLICKER_SECS seconds of a phase produce a half-second flicker strobe, and
// expiry raises a sticky done flag that only a new start clears.
// All outputs come straight from flops whose next values are computed from
// the next state, so output timing matches the internal state exactly and no
// input reaches an output combinationally.
module phase_timer #(
  parameter int unsigned HALF_SEC_TICKS = 32'd25_000_000,
  parameter logic [4:0]  FLICKER_SECS   = 5'd5
) (
  input  logic        clk,
  input  logic        reset,
  phase_timer_if.slave tif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

  // Prescaler value on which a half-second tick is taken.
  localparam logic [31:0] PRE_LAST     = HALF_SEC_TICKS - 32'd1;
  // Flicker window expressed in half-seconds.
  localparam logic [5:0]  FLICK_HALVES = {FLICKER_SECS, 1'b0};

  state_e      state_q, state_d;
  logic [31:0] pre_q, pre_d;
  logic [5:0]  half_cnt_q, half_cnt_d;
  logic        done_q, done_d;
  logic        flicker_q, flicker_d;
  logic        busy_q, busy_d;
  logic [4:0]  remaining_q, remaining_d;
  logic [5:0]  rem_sum_s;

  // Next-state logic: start always wins, otherwise the FSM advances.
  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    half_cnt_d = half_cnt_q;
    done_d     = done_q;

    if (tif.t_start) begin
      half_cnt_d = {tif.t_length, 1'b0};
      pre_d      = 32'd0;
      if (tif.t_length != 5'd0) begin
        state_d = ST_RUN;
        done_d  = 1'b0;
      end else begin
        // Zero-length phase expires immediately.
        state_d = ST_EXPIRED;
        done_d  = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_d = 1'b0;
        end
        ST_RUN: begin
          done_d = 1'b0;
          if (pre_q == PRE_LAST) begin
            pre_d = 32'd0;
            if (half_cnt_q == 6'd1) begin
              half_cnt_d = 6'd0;
              state_d    = ST_EXPIRED;
              done_d     = 1'b1;
            end else if (half_cnt_q != 6'd0) begin
              half_cnt_d = half_cnt_q - 6'd1;
            end else begin
              // Unreachable in practice; never wrap below zero.
              half_cnt_d = 6'd0;
              state_d    = ST_EXPIRED;
              done_d     = 1'b1;
            end
          end else begin
            pre_d = pre_q + 32'd1;
          end
        end
        ST_EXPIRED: begin
          done_d = 1'b1;
        end
        default: begin
          state_d    = ST_IDLE;
          pre_d      = 32'd0;
          half_cnt_d = 6'd0;
          done_d     = 1'b0;
        end
      endcase
    end
  end

  // Output next values derived from the next state so registered outputs track it.
  always_comb begin
    busy_d      = 1'b0;
    remaining_d = 5'd0;
    flicker_d   = 1'b0;
    rem_sum_s   = half_cnt_d + 6'd1;

    case (state_d)
      ST_RUN: begin
        busy_d      = 1'b1;
        remaining_d = rem_sum_s[5:1];
        flicker_d   = half_cnt_d[0] & (half_cnt_d <= FLICK_HALVES);
      end
      ST_EXPIRED: begin
        busy_d      = 1'b0;
        remaining_d = 5'd0;
        flicker_d   = 1'b1;
      end
      ST_IDLE: begin
        busy_d      = 1'b0;
        remaining_d = 5'd0;
        flicker_d   = 1'b0;
      end
      default: begin
        busy_d      = 1'b0;
        remaining_d = 5'd0;
        flicker_d   = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pre_q       <= 32'd0;
      half_cnt_q  <= 6'd0;
      done_q      <= 1'b0;
      flicker_q   <= 1'b0;
      busy_q      <= 1'b0;
      remaining_q <= 5'd0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      half_cnt_q  <= half_cnt_d;
      done_q      <= done_d;
      flicker_q   <= flicker_d;
      busy_q      <= busy_d;
      remaining_q <= remaining_d;
    end
  end

  assign tif.t_done      = done_q;
  assign tif.t_flicker   = flicker_q;
  assign tif.t_busy      = busy_q;
  assign tif.t_remaining = remaining_q;

endmodule

// File: tb/tb_phase_timer.sv
// Self-checking bench for phase_timer with H=4 and a 2-second flicker window.
// Expected outputs come from the closed-form timing rules: after a start with
// length L, cycle k shows half-count 2L - k/H until k reaches 2L*H, after
// which the timer is expired.
module tb_phase_timer;
  localparam int         H = 4;
  localparam logic [4:0] F = 5'd2;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: whether a start has happened since reset,
  // the latched length and cycles elapsed since that start.
  bit m_started = 1'b0;
  int m_len     = 0;
  int m_k       = 0;

  phase_timer_if tif ();

  phase_timer #(
    .HALF_SEC_TICKS(H),
    .FLICKER_SECS  (F)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .tif  (tif.slave)
  );

  always #5 clk = ~clk;

  task automatic check_outputs(input string tag);
    logic       e_fl, e_dn, e_bz;
    logic [4:0] e_rem;
    int         half;
    e_fl = 1'b0; e_dn = 1'b0; e_bz = 1'b0; e_rem = 5'd0;
    if (m_started) begin
      if (m_k >= 2 * m_len * H) begin
        e_fl = 1'b1;
        e_dn = 1'b1;
      end else begin
        half  = 2 * m_len - m_k / H;
        e_bz  = 1'b1;
        e_rem = 5'((half + 1) / 2);
        e_fl  = ((half % 2) == 1) && (half <= 2 * int'(F));
      end
    end
    n_tests++;
    assert (tif.t_done === e_dn) else begin
      n_fail++;
      $error("FAIL %s t_done k=%0d got %b expected %b", tag, m_k, tif.t_done, e_dn);
    end
    n_tests++;
    assert (tif.t_flicker === e_fl) else begin
      n_fail++;
      $error("FAIL %s t_flicker k=%0d got %b expected %b", tag, m_k, tif.t_flicker, e_fl);
    end
    n_tests++;
    assert (tif.t_busy === e_bz) else begin
      n_fail++;
      $error("FAIL %s t_busy k=%0d got %b expected %b", tag, m_k, tif.t_busy, e_bz);
    end
    n_tests++;
    assert (tif.t_remaining === e_rem) else begin
      n_fail++;
      $error("FAIL %s t_remaining k=%0d got %0d expected %0d", tag, m_k, tif.t_remaining, e_rem);
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, check #1 later.
  task automatic step(input logic st, input logic [4:0] len, input string tag);
    tif.t_start  = st;
    tif.t_length = len;
    @(posedge clk);
    if (st) begin
      m_started = 1'b1;
      m_len     = int'(len);
      m_k       = 0;
    end else if (m_started) begin
      m_k++;
    end else begin
      m_k = 0;
    end
    #1;
    tif.t_start  = 1'b0;
    tif.t_length = 5'($urandom_range(0, 31));
    check_outputs(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, tag);
  endtask

  initial begin
    int len_r, cyc_r;
    reset        = 1'b1;
    tif.t_start  = 1'b0;
    tif.t_length = 5'd0;

    // Reset state.
    @(negedge clk);
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    run(3, "idle");

    // Basic phase, L=3: busy k0..23, flicker window, done at k=24.
    step(1'b1, 5'd3, "l3");
    run(29, "l3");

    // Restart from EXPIRED with L=1: done drops at k=0, back at k=8.
    step(1'b1, 5'd1, "l1");
    run(11, "l1");

    // Restart mid-run: L=5, then L=2 at k=10.
    step(1'b1, 5'd5, "l5");
    run(9, "l5");
    step(1'b1, 5'd2, "restart");
    run(20, "restart");

    // Zero length: expired immediately, never busy.
    step(1'b1, 5'd0, "l0");
    run(3, "l0");

    // Start on the very edge of the 1->0 transition.
    step(1'b1, 5'd1, "edge");
    run(2 * 1 * H - 1, "edge");
    step(1'b1, 5'd2, "edge_start");
    run(20, "edge_start");

    // Held start restarts on every edge.
    for (int i = 0; i < 5; i++) step(1'b1, 5'd3, "held");
    run(6, "held");

    // Randomized phases with random restart points.
    for (int it = 0; it < 10; it++) begin
      len_r = $urandom_range(0, 6);
      cyc_r = $urandom_range(0, 2 * len_r * H + 6);
      step(1'b1, 5'(len_r), "rand");
      run(cyc_r, "rand");
    end

    // Asynchronous reset at k=7 of a run.
    step(1'b1, 5'd4, "pre_rst");
    run(7, "pre_rst");
    #2;
    reset = 1'b1;
    #1;
    m_started = 1'b0;
    m_k       = 0;
    check_outputs("async_rst");
    @(posedge clk);
    @(negedge clk);
    check_outputs("rst_hold");
    reset = 1'b0;
    run(5, "post_rst_idle");
    step(1'b1, 5'd2, "post_rst");
    run(20, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
